// File: rtl/chacha_ks_xor_stream.sv
// ChaCha keystream XOR stream engine.
// Pulls 512-bit keystream blocks from a keystream unit, splits each block into
// four 128-bit lanes and XORs one lane onto every accepted payload beat. Bytes
// outside in_keep are forced to zero. A single output register gives full
// throughput. out_ct carries the ciphertext view of each beat for the
// Poly1305 payload port.
module chacha_ks_xor_stream (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dec,
    output logic         ks_req,
    input  logic         ks_valid,
    input  logic [511:0] ks_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [15:0]  in_keep,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [15:0]  out_keep,
    output logic         out_last,
    output logic [127:0] out_ct,
    output logic [63:0]  pld_bytes,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        RUN,
        DRAIN
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [511:0]   ks_buf;
    logic [1:0]     lane_cnt;
    logic           dec_q;
    logic [127:0]   ct_q;

    logic           in_xfer;
    logic           drain_done;
    logic [127:0]   lane_word;
    logic [127:0]   byte_mask;
    logic [127:0]   masked_in;
    logic [127:0]   xor_word;
    logic [4:0]     keep_cnt;

    // A new start always takes priority, so no beat is accepted in the start cycle.
    assign in_ready   = (state == RUN) && (!out_valid || out_ready) && !start;
    assign in_xfer    = in_valid && in_ready;
    assign drain_done = (state == DRAIN) && (!out_valid || out_ready) && !start;
    assign ks_req     = (state == FETCH);
    assign lane_word  = ks_buf[{lane_cnt, 7'd0} +: 128];
    assign masked_in  = in_data & byte_mask;
    assign xor_word   = (in_data ^ lane_word) & byte_mask;
    assign out_ct     = ct_q;

    // Expand keep bits into a byte mask and count the payload bytes of this beat.
    always_comb begin
        byte_mask = '0;
        keep_cnt  = '0;
        for (int j = 0; j < 16; j++) begin
            byte_mask[8*j +: 8] = {8{in_keep[j]}};
            keep_cnt            = keep_cnt + {4'd0, in_keep[j]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start restarts from any state, lane 3 triggers a refetch.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                FETCH: state_nxt = WAIT;
                WAIT: begin
                    if (ks_valid) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (in_xfer) begin
                        if (in_last) begin
                            state_nxt = DRAIN;
                        end else if (lane_cnt == 2'd3) begin
                            state_nxt = FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Keystream buffer and lane counter; start drops the buffered block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_buf   <= '0;
            lane_cnt <= '0;
        end else if (start) begin
            ks_buf   <= '0;
            lane_cnt <= '0;
        end else if ((state == WAIT) && ks_valid) begin
            ks_buf   <= ks_data;
            lane_cnt <= '0;
        end else if (in_xfer) begin
            lane_cnt <= lane_cnt + 2'd1;
        end
    end

    // Direction is latched at start and held for the whole message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (start) begin
            dec_q <= dec;
        end
    end

    // Output register: load on input transfer, empty on output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            ct_q      <= '0;
        end else if (start) begin
            out_valid <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= xor_word;
            out_keep  <= in_keep;
            out_last  <= in_last;
            ct_q      <= dec_q ? masked_in : xor_word;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Running payload byte count, held after the message until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pld_bytes <= '0;
        end else if (start) begin
            pld_bytes <= '0;
        end else if (in_xfer) begin
            pld_bytes <= pld_bytes + {59'd0, keep_cnt};
        end
    end

    // Done pulses the cycle after the last beat leaves the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= drain_done;
        end
    end

endmodule

// File: doc/chacha_ks_xor_stream.md
CHACHA_KS_XOR_STREAM -- requirements
Module: chacha_ks_xor_stream

Interface
REQ-001 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse that begins a message and aborts any message in progress.
REQ-004 SHALL have port dec  input  1  sampled on start; 0 = encrypt, 1 = decrypt.
REQ-005 SHALL have port ks_req  output  1  one-cycle keystream block request to the keystream unit.
REQ-006 SHALL have port ks_valid  input  1  keystream block valid.
REQ-007 SHALL have port ks_data  input  512  keystream block; lane i = ks_data[128*i+127:128*i], lane 0 consumed first.
REQ-008 SHALL have ports in_valid/in_ready  input/output  1  payload beat handshake.
REQ-009 SHALL have ports in_data 128, in_keep 16, in_last 1  input  payload beat; keep bit j qualifies byte bits [8j+7:8j].
REQ-010 SHALL have ports out_valid/out_ready  output/input  1  result beat handshake.
REQ-011 SHALL have ports out_data 128, out_keep 16, out_last 1  output  XOR result beat.
REQ-012 SHALL have port out_ct  output  128  ciphertext copy of the beat for the Poly1305 payload port (out_data if dec=0, registered in_data if dec=1), keep-masked.
REQ-013 SHALL have port pld_bytes  output  64  count of payload bytes accepted in the current message.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the last beat leaves the output register.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT, RUN, DRAIN.
REQ-016 IDLE: in_ready=0; start -> FETCH.
REQ-017 FETCH: ks_req=1 for exactly this cycle; next state WAIT (ks_req thus asserts the cycle after start).
REQ-018 WAIT: in_ready=0; on ks_valid capture ks_data into 512-bit buffer, lane counter=0, -> RUN; ks_valid in any other state is ignored.
REQ-019 RUN: in_ready = !out_valid || out_ready (single output register, full throughput).
REQ-020 On in transfer: out_data <= in_data XOR lane, bytes with keep=0 forced to 0; out_keep/out_last copied; out_valid<=1 next cycle (latency 1).
REQ-021 Each accepted beat consumes one full 128-bit lane regardless of keep; lane counter increments mod 4.
REQ-022 Transfer with in_last=1 -> DRAIN; otherwise transfer on lane 3 -> FETCH (in_ready=0 until new block captured).
REQ-023 Keep SHALL be LSB-contiguous; pld_bytes += popcount(in_keep) per transfer, 64-bit wrap.
REQ-024 in_keep=0 with in_last=1 SHALL be legal: zero-byte terminating beat, lane still consumed.
REQ-025 DRAIN: in_ready=0; when output register empties (out_valid&&out_ready, or already empty) pulse done and -> IDLE.
REQ-026 out_valid SHALL hold, and out_* SHALL be stable, while out_ready=0.
REQ-027 start in any state SHALL clear out_valid, lane counter, pld_bytes, drop the buffered block, and -> FETCH; start wins over a simultaneous in transfer (beat not accepted).
REQ-028 pld_bytes SHALL hold its final value in IDLE until next start.

Reset
REQ-029 On rst_n=0 asynchronously: state IDLE, ks_req=0, in_ready=0, out_valid=0, out_data=0, out_keep=0, out_last=0, pld_bytes=0, done=0, keystream buffer 0.
REQ-030 Reset deasserted mid-message SHALL require a new start; no stale beat emitted.

Verification
REQ-031 start, ks_data lane0=all 0xFF, beat data=0x00..0F keep=FFFF last=1 -> out_data=~in_data, out_keep=FFFF, done one cycle after out handshake, pld_bytes=16.
REQ-032 Five full beats, out_ready=1 -> exactly two ks_req pulses, beat 5 uses lane 0 of second block, pld_bytes=80.
REQ-033 Last beat keep=0x0007 -> out_data bytes 3..15 zero, pld_bytes adds 3; dec=1 -> out_ct equals masked in_data.
REQ-034 out_ready held 0 for 5 cycles with a beat pending -> in_ready=0, out_* stable, no beat lost or duplicated.
REQ-035 start asserted mid-message during RUN -> out_valid cleared next cycle, ks_req next cycle, pld_bytes=0, old buffer not reused.
REQ-036 rst_n pulsed low during WAIT, then ks_valid -> ignored, all outputs at reset values, state IDLE.
